// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

  // Decimal digits needed to hold any w-bit unsigned value (log10(2) ~ 0.301, rounded up).
  function automatic int bcd_digits(input int w);
    return (w * 301 + 999) / 1000;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next decimal digit.
module bcd_digit_adj (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  // Pure combinational correction; a digit >= 5 never exceeds 9 here, so +3 cannot overflow 4 bits.
  always_comb begin
    digit_out = digit_in;
    if (digit_in >= 4'd5) begin
      digit_out = digit_in + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative shift-and-add-3 binary-to-BCD converter with start/done handshake.
// One conversion takes BIN_W shift cycles; the result stays held until the next one completes.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int SIGNED = 0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [BIN_W-1:0]                   bin_in,
  output logic                               ready,
  output logic                               busy,
  output logic                               done,
  output logic                               neg,
  output logic [4*bcd_digits(BIN_W)-1:0]     bcd_out
);

  localparam int DIGITS = bcd_digits(BIN_W);
  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_W - 1);

  bcd_state_t        state_q;
  logic [WORK_W-1:0] work_q;
  logic [CNT_W-1:0]  count_q;
  logic              sign_q;

  logic [BIN_W-1:0]  mag;
  logic              in_neg;
  logic [BCD_W-1:0]  adj_bcd;
  logic [WORK_W-1:0] adj_work;
  logic [WORK_W-1:0] work_next;

  // Magnitude and sign of the incoming value; two's complement is only honoured in signed mode.
  always_comb begin
    in_neg = (SIGNED != 0) && bin_in[BIN_W-1];
    mag    = bin_in;
    if (in_neg) begin
      mag = (~bin_in) + BIN_W'(1);
    end
  end

  // One correction stage per digit, applied to the BCD half of the work register.
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_in  (work_q[BIN_W + 4*i +: 4]),
      .digit_out (adj_bcd[4*i +: 4])
    );
  end

  // Corrected register shifted left by one: the next double-dabble step.
  always_comb begin
    adj_work  = {adj_bcd, work_q[BIN_W-1:0]};
    work_next = {adj_work[WORK_W-2:0], 1'b0};
  end

  // Handshake FSM and datapath: load on accept, shift BIN_W times, publish result on the last shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      work_q  <= '0;
      count_q <= '0;
      sign_q  <= 1'b0;
      bcd_out <= '0;
      neg     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            work_q  <= {{BCD_W{1'b0}}, mag};
            sign_q  <= in_neg;
            count_q <= '0;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          work_q  <= work_next;
          count_q <= count_q + 1'b1;
          if (count_q == LAST_SHIFT) begin
            state_q <= DONE;
            bcd_out <= work_next[BIN_W +: BCD_W];
            neg     <= sign_q;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Status outputs decoded purely from registered state.
  always_comb begin
    ready = (state_q == IDLE) || (state_q == DONE);
    busy  = (state_q == SHIFT);
    done  = (state_q == DONE);
  end

endmodule
